// File: rtl/uart_rx_if.sv
// Receive-side byte handshake for uart_rx: one-deep valid/ready holding register
// plus the framing-error and overrun pulses.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data_out, data_valid, frame_err, overrun,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, frame_err, overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation at mid-bit, mid-bit data/stop
// sampling, and a one-deep holding register with framing-error and overrun pulses.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      tick,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic                 armed;
    logic [SW-1:0]        s_cnt;
    logic [NW-1:0]        n_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_m;
    logic                 rx_s;

    // NOTE: both synchronizer flops reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    logic stop_sample;
    logic deliver;
    logic consume;

    assign stop_sample = tick && (state == STOP) && (s_cnt == S_END);
    assign deliver     = stop_sample && rx_s;
    assign consume     = bus.data_valid && bus.data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            armed          <= 1'b0;
            s_cnt          <= '0;
            n_cnt          <= '0;
            shreg          <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.frame_err <= stop_sample && !rx_s;
            bus.overrun   <= 1'b0;

            // A consume in the delivery cycle frees the slot for the new byte.
            if (deliver) begin
                if (!bus.data_valid || bus.data_ready) begin
                    bus.data_out   <= shreg;
                    bus.data_valid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end else if (consume) begin
                bus.data_valid <= 1'b0;
            end

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (rx_s) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= START;
                            s_cnt <= '0;
                            armed <= 1'b0;
                        end
                    end
                    START: begin
                        if (s_cnt == S_MID) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                armed <= 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (s_cnt == S_END) begin
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            s_cnt <= '0;
                            n_cnt <= n_cnt + 1'b1;
                            if (n_cnt == N_LAST) state <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // Returning unarmed means a held-low break cannot restart a frame.
                        if (s_cnt == S_END) begin
                            state <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tick-arithmetic reference model compared every
// cycle, directed scenarios with literal expectations, then randomized frames.
module tb_uart_rx;
    localparam int DB = 8;
    localparam int OS = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tick generator: spacing drawn from [gap_min, gap_max] clocks.
    int gap_min  = 4;
    int gap_max  = 4;
    int gap_left = 0;
    always @(negedge clk) begin
        if (gap_left <= 1) begin
            tick     = 1'b1;
            gap_left = int'($urandom_range(gap_max, gap_min));
        end else begin
            tick     = 1'b0;
            gap_left = gap_left - 1;
        end
    end

    int cyc      = 0;
    int tick_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    // Reference model: positions within a frame are counted in ticks from the
    // detecting tick; rx_s is rx delayed by two clocks.
    bit          m_s1 = 1'b1, m_s2 = 1'b1;
    bit          busy = 1'b0, armed = 1'b0;
    int          tpos = 0;
    logic [DB-1:0] m_byte = '0, m_data = '0;
    bit          m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    initial forever begin
        bit rxs, deliver, bad;
        int k;
        @(posedge clk);
        rxs  = m_s2;
        m_s2 = m_s1;
        m_s1 = rx;
        if (reset) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            busy = 1'b0; armed = 1'b0;
            m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        end else begin
            deliver = 1'b0;
            bad     = 1'b0;
            if (tick) begin
                if (!busy) begin
                    if (rxs) armed = 1'b1;
                    else if (armed) begin busy = 1'b1; tpos = 0; armed = 1'b0; end
                end else begin
                    tpos++;
                    if (tpos == OS / 2) begin
                        if (rxs) begin busy = 1'b0; armed = 1'b1; end
                    end else if (tpos > OS / 2 && (tpos - OS / 2) % OS == 0) begin
                        k = (tpos - OS / 2) / OS - 1;
                        if (k < DB) m_byte[k] = rxs;
                        else begin
                            busy = 1'b0;
                            if (rxs) deliver = 1'b1;
                            else bad = 1'b1;
                        end
                    end
                end
            end
            m_ferr = bad;
            m_ovr  = 1'b0;
            if (deliver) begin
                if (!m_valid || bus.data_ready) begin m_data = m_byte; m_valid = 1'b1; end
                else m_ovr = 1'b1;
            end else if (m_valid && bus.data_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare process plus event monitors, sampled 1 time unit after each edge.
    bit chk_en   = 1'b0;
    bit dv_prev  = 1'b0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int rise_cyc = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("data_valid", 32'(bus.data_valid), 32'(m_valid));
            check("data_out",   32'(bus.data_out),   32'(m_data));
            check("frame_err",  32'(bus.frame_err),  32'(m_ferr));
            check("overrun",    32'(bus.overrun),    32'(m_ovr));
            if (bus.frame_err === 1'b1) ferr_cnt++;
            if (bus.overrun === 1'b1) ovr_cnt++;
            if (bus.data_valid === 1'b1 && !dv_prev) rise_cyc = cyc;
            dv_prev = (bus.data_valid === 1'b1);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_until_tick(input int target);
        int guard = 0;
        while (tick_cnt < target) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                $display("FAIL tick_wait: tick %0d never reached (at %0d)", target, tick_cnt);
                $fatal(1, "tick wait expired");
            end
        end
    endtask

    task automatic wait_ticks(input int n);
        wait_until_tick(tick_cnt + n);
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
    endtask

    int fall_cyc = 0;

    // One frame; bit edges follow OS ticks. pulse_at_stop raises data_ready for the
    // stop-sampling cycle (needs tick spacing >= 3). abort_bit >= 0 resets mid-bit.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit,
                              input bit pulse_at_stop, input int abort_bit);
        int c0;
        wait_ticks(1);
        rx       = 1'b0;
        c0       = tick_cnt;
        fall_cyc = cyc;
        wait_until_tick(c0 + OS);
        for (int i = 0; i < DB; i++) begin
            rx = b[i];
            if (i == abort_bit) begin
                wait_until_tick(c0 + OS * (i + 1) + OS / 2);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                rx    = 1'b1;
                return;
            end
            wait_until_tick(c0 + OS * (i + 2));
        end
        rx = stop_bit;
        if (pulse_at_stop) begin
            wait_until_tick(c0 + OS / 2 + OS * (DB + 1));
            #1;
            while (!tick) begin
                @(negedge clk);
                #1;
            end
            bus.data_ready = 1'b1;
            @(negedge clk);
            bus.data_ready = 1'b0;
        end
        wait_until_tick(c0 + OS * (DB + 2));
        wait_ticks(2);
    endtask

    initial begin
        bus.data_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_data_valid", 32'(bus.data_valid), 32'd0);
        check("rst_data_out",   32'(bus.data_out),   32'd0);
        check("rst_frame_err",  32'(bus.frame_err),  32'd0);
        check("rst_overrun",    32'(bus.overrun),    32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_ticks(20);

        // Clean frame, ready held high: byte delivered then consumed next cycle.
        bus.data_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        check("clean_data",    32'(bus.data_out),    32'h0000_00A5);
        check("clean_latency", 32'(rise_cyc - fall_cyc), 32'd612);
        check("clean_valid",   32'(bus.data_valid),  32'd0);
        check("clean_ferr",    32'(ferr_cnt), 32'd0);
        check("clean_ovr",     32'(ovr_cnt),  32'd0);

        // Back-to-back with the register held full.
        bus.data_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        check("held_data",  32'(bus.data_out),   32'h0000_003C);
        check("held_valid", 32'(bus.data_valid), 32'd1);
        check("held_ovr",   32'(ovr_cnt), 32'd1);
        pulse_ready();
        #1;
        check("consume_valid", 32'(bus.data_valid), 32'd0);

        // Consume in the same cycle as the next delivery.
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'h81, 1'b1, 1'b1, -1);
        check("swap_data",  32'(bus.data_out),   32'h0000_0081);
        check("swap_valid", 32'(bus.data_valid), 32'd1);
        check("swap_ovr",   32'(ovr_cnt), 32'd1);

        // Low stop bit followed by a 40-bit break.
        send_frame(8'h55, 1'b0, 1'b0, -1);
        wait_ticks(40 * OS);
        rx = 1'b1;
        wait_ticks(20);
        check("break_ferr",  32'(ferr_cnt), 32'd1);
        check("break_valid", 32'(bus.data_valid), 32'd1);
        check("break_data",  32'(bus.data_out),   32'h0000_0081);
        pulse_ready();
        send_frame(8'h12, 1'b1, 1'b0, -1);
        check("after_break_data",  32'(bus.data_out),   32'h0000_0012);
        check("after_break_valid", 32'(bus.data_valid), 32'd1);

        // Start glitch of three ticks.
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(20);
        check("glitch_ferr",  32'(ferr_cnt), 32'd1);
        check("glitch_ovr",   32'(ovr_cnt),  32'd1);
        check("glitch_data",  32'(bus.data_out), 32'h0000_0012);
        pulse_ready();
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        check("after_glitch_data", 32'(bus.data_out), 32'h0000_00FF);

        // Reset during data bit 4.
        send_frame(8'hF0, 1'b1, 1'b0, 4);
        #1;
        check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
        check("mid_rst_data",  32'(bus.data_out),   32'd0);
        check("mid_rst_ferr",  32'(bus.frame_err),  32'd0);
        check("mid_rst_ovr",   32'(bus.overrun),    32'd0);
        wait_ticks(12 * OS);
        check("mid_rst_nodeliver", 32'(bus.data_valid), 32'd0);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        check("zero_data",  32'(bus.data_out),   32'd0);
        check("zero_valid", 32'(bus.data_valid), 32'd1);

        // Randomized frames, tick spacing, readiness and stop bits.
        for (int f = 0; f < 30; f++) begin
            logic [DB-1:0] b;
            logic          stop;
            bit            pulse;
            gap_min = int'($urandom_range(3, 1));
            gap_max = gap_min + int'($urandom_range(2, 0));
            b       = DB'($urandom);
            stop    = ($urandom_range(7, 0) != 0);
            bus.data_ready = 1'($urandom_range(1, 0));
            pulse   = (gap_min >= 3) && !bus.data_ready && ($urandom_range(1, 0) == 1);
            send_frame(b, stop, pulse, -1);
            if (!stop) begin
                rx = 1'b1;
                wait_ticks(4);
            end
            if ($urandom_range(1, 0) == 1) pulse_ready();
        end

        wait_ticks(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
